// File: rtl/sp_writeback_ctrl_pkg.sv
// sp_writeback_ctrl_pkg: shared accelerator constants, FSM state type and width helpers
package sp_writeback_ctrl_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int BUS_WIDTH_DEF = 64;
  localparam int MAX_DIM = BUS_WIDTH_DEF / DATA_WIDTH_DEF;
  localparam int ELEM_WIDTH = 2 * DATA_WIDTH_DEF;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  function automatic int max_dim(int bus, int data);
    return bus / data;
  endfunction
  function automatic int elem_width(int data);
    return 2 * data;
  endfunction
endpackage

// File: rtl/sp_wb_index_cnt.sv
// sp_wb_index_cnt: row-major row/col walker producing the buffer slot index
module sp_wb_index_cnt #(
  parameter int MD = 2,
  parameter int DIM_W = 2,
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [DIM_W-1:0]  dim_m,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col,
  output logic [SLOT_W-1:0] slot
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      col <= (col == dim_m - 1'b1) ? '0 : col + 1'b1;
      row <= (col == dim_m - 1'b1) ? row + 1'b1 : row;
    end
  end
  assign slot = SLOT_W'(int'(row) * MD + int'(col));
endmodule

// File: rtl/sp_writeback_ctrl.sv
// sp_writeback_ctrl: gathers matmul result elements into a packed matrix and issues one scratchpad write
module sp_writeback_ctrl
  import sp_writeback_ctrl_pkg::*;
#(
  parameter int SP_NTARGETS = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     start_i,
  input  logic [$clog2(SP_NTARGETS)-1:0]           sp_number_i,
  input  logic [$clog2(BUS_WIDTH/DATA_WIDTH):0]    dim_n_i,
  input  logic [$clog2(BUS_WIDTH/DATA_WIDTH):0]    dim_m_i,
  input  logic                                     elem_valid_i,
  input  logic [2*DATA_WIDTH-1:0]                  elem_data_i,
  output logic                                     elem_ready_o,
  output logic                                     sp_write_enable_o,
  output logic [$clog2(SP_NTARGETS)-1:0]           sp_number_o,
  output logic [ADDR_WIDTH-1:0]                    sp_address_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*2*DATA_WIDTH-1:0] c_matrix_o,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     err_o
);
  localparam int MD = max_dim(BUS_WIDTH, DATA_WIDTH);
  localparam int EW = elem_width(DATA_WIDTH);
  localparam int DW = $clog2(MD) + 1;
  localparam int SW = (MD > 1) ? $clog2(MD * MD) : 1;
  state_t state;
  logic [DW-1:0] dn, dm, row, col;
  logic [SW-1:0] slot;
  logic legal, accept, hs, last;
  assign legal = (dim_n_i != '0) && (dim_n_i <= DW'(MD)) && (dim_m_i != '0) && (dim_m_i <= DW'(MD));
  assign accept = start_i && legal && (state == IDLE);
  assign hs = elem_valid_i && (state == COLLECT);
  assign last = (row == dn - 1'b1) && (col == dm - 1'b1);
  assign elem_ready_o = (state == COLLECT);
  assign sp_write_enable_o = (state == WRITE);
  assign done_o = (state == DONE);
  assign busy_o = (state != IDLE);
  assign sp_address_o = '0;
  sp_wb_index_cnt #(.MD(MD), .DIM_W(DW), .SLOT_W(SW)) u_idx (
    .clk(clk_i),
    .rst(rst_i),
    .clear(accept),
    .advance(hs),
    .dim_m(dm),
    .row(row),
    .col(col),
    .slot(slot)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      c_matrix_o <= '0;
      sp_number_o <= '0;
      dn <= '0;
      dm <= '0;
      err_o <= 1'b0;
    end else begin
      // any start that cannot be accepted is flagged but never disturbs a running job
      err_o <= start_i && !accept;
      case (state)
        IDLE: if (accept) begin
          state <= COLLECT;
          sp_number_o <= sp_number_i;
          dn <= dim_n_i;
          dm <= dim_m_i;
          c_matrix_o <= '0;
        end
        COLLECT: if (hs) begin
          c_matrix_o[int'(slot)*EW +: EW] <= elem_data_i;
          if (last) state <= WRITE;
        end
        WRITE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sp_writeback_ctrl.md
SP_WRITEBACK_CTRL -- requirements
Module: sp_writeback_ctrl

Interface
REQ-001 SHALL have parameter SP_NTARGETS, default 4, number of scratchpad targets.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, operand width; result elements are 2*DATA_WIDTH.
REQ-003 SHALL have parameter BUS_WIDTH, default 64, bus width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, scratchpad address width.
REQ-005 SHALL derive MAX_DIM = BUS_WIDTH/DATA_WIDTH, the max matrix dimension.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk_i  in  1  rising-edge clock.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 start_i  in  1  one-cycle job start; latches configuration.
REQ-010 sp_number_i  in  $clog2(SP_NTARGETS)  destination scratchpad target.
REQ-011 dim_n_i  in  $clog2(MAX_DIM)+1  result row count, legal 1..MAX_DIM.
REQ-012 dim_m_i  in  $clog2(MAX_DIM)+1  result column count, legal 1..MAX_DIM.
REQ-013 elem_valid_i  in  1  result element valid from matmul engine.
REQ-014 elem_data_i  in  2*DATA_WIDTH  result element, row-major order.
REQ-015 elem_ready_o  out  1  element accepted when valid and ready are both high.
REQ-016 sp_write_enable_o  out  1  scratchpad write strobe.
REQ-017 sp_number_o  out  $clog2(SP_NTARGETS)  latched target.
REQ-018 sp_address_o  out  ADDR_WIDTH  scratchpad address.
REQ-019 c_matrix_o  out  MAX_DIM*MAX_DIM*2*DATA_WIDTH  packed result matrix; slot k occupies bits [(k+1)*2*DATA_WIDTH-1 : k*2*DATA_WIDTH].
REQ-020 busy_o  out  1  high when the FSM is not in IDLE.
REQ-021 done_o  out  1  one-cycle job-complete pulse.
REQ-022 err_o  out  1  one-cycle error pulse.

Function
REQ-023 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-024 IDLE->COLLECT on start_i with legal dims: latch sp_number_i, dim_n_i, dim_m_i; zero the buffer; clear row/col counters.
REQ-025 start_i with a dim of 0 or >MAX_DIM SHALL pulse err_o the next cycle and remain in IDLE.
REQ-026 start_i outside IDLE SHALL be ignored and pulse err_o; the job in progress is unaffected.
REQ-027 elem_ready_o SHALL be 1 only in COLLECT.
REQ-028 Each handshake SHALL write slot row*MAX_DIM+col; col increments, and at col==dim_m-1 col wraps to 0 and row increments.
REQ-029 Slots outside the dim_n x dim_m region SHALL hold zero.
REQ-030 On the handshake of element dim_n*dim_m SHALL go to WRITE; no further element is accepted.
REQ-031 WRITE SHALL assert sp_write_enable_o for exactly one cycle with sp_address_o=0, then go to DONE.
REQ-032 DONE SHALL pulse done_o for one cycle, then return to IDLE.
REQ-033 Latency: last handshake at cycle t gives sp_write_enable_o at t+1, done_o at t+2, and busy_o low at t+3.
REQ-034 sp_write_enable_o SHALL be 0 in every state except WRITE, keeping the scratchpad read path available.
REQ-035 c_matrix_o and sp_number_o SHALL hold their values after DONE until the next accepted start_i.
REQ-036 elem_valid_i while not in COLLECT SHALL be ignored and SHALL NOT assert err_o.

Reset
REQ-037 rst_i SHALL set: state IDLE, buffer 0, counters 0, and all outputs 0.
REQ-038 rst_i mid-job SHALL abort the job with no write strobe and no done_o pulse.
REQ-039 rst_i SHALL take priority over start_i and handshakes in the same cycle.

Structure
REQ-040 MAX_DIM, the FSM state enum, and the element-width constant SHALL reside in the shared accelerator package.
REQ-041 The row/col index counter SHALL be sub-module sp_wb_index_cnt (inputs: clear, advance, dim_m; outputs: row, col, slot).
REQ-042 Target size is 120-400 RTL lines; the block SHALL contain no arithmetic beyond the counters and the slot index.

Verification (MAX_DIM=2, DATA_WIDTH=32)
REQ-043 start, sp=1, n=m=2, elements 1,2,3,4 back-to-back -> we pulse at t+1 with c_matrix slots {4,3,2,1}, sp_number_o=1, done at t+2.
REQ-044 n=1, m=2, elements 7,9 -> slots 0,1 = 7,9; slots 2,3 = 0; exactly one we pulse.
REQ-045 start with n=0, then start with m=3 -> err_o pulse for each, busy_o stays 0, no we.
REQ-046 rst_i after 2 of 4 elements -> busy_o 0 next cycle, no we or done; a new job then completes correctly.
REQ-047 valid toggling 1,0,1,0 with gaps plus a start_i during COLLECT -> err_o pulse, slot order preserved, single done.
